lenet_predict_fmap_addr_gen: RTL and testbench
==============================================

# lenet_predict_fmap_addr_gen

Feature-map address generator for the LeNet predict datapath. It sweeps channel, row and column over one feature map and emits one flat buffer address per cycle under valid/ready flow control. Each address is `ch * CH_SIZE + row * COLS + col`. The `ch * CH_SIZE` term is formed by the team's unsigned 3×11→13 multiplier, `lenet_predict_mul_3ns_11ns_13_1_1`. The block sits directly upstream of the conv/pool buffer read port and is started with the standard `ap_start`/`ap_done` block protocol.

## Interface
Parameters:
- `NUM_CH`, 6: channels per feature map.
- `ROWS`, 14: rows per channel.
- `COLS`, 14: columns per channel.
- `CH_W`, 3: channel index width (multiplier `din0`).
- `OFF_W`, 11: in-channel offset width (multiplier `din1`).
- `ADDR_W`, 13: address width (multiplier `dout`).

Ports (one clock; reset is asynchronous and active-low):
- `ap_clk`  in  1  clock.
- `ap_rst_n`  in  1  asynchronous active-low reset.
- `ap_start`  in  1  start request; sampled only in IDLE.
- `ap_done`  out  1  one-cycle pulse when the sweep completes.
- `ap_idle`  out  1  high in IDLE.
- `ap_ready`  out  1  one-cycle pulse, same cycle as `ap_done`.
- `addr`  out  ADDR_W  flat buffer address.
- `addr_valid`  out  1  `addr`, `addr_ch` and `addr_last` are valid.
- `addr_ready`  in  1  consumer accepts `addr`.
- `addr_last`  out  1  marks the final address of the sweep.
- `addr_ch`  out  CH_W  channel index of the current `addr`.

## Operation
- FSM states:
  - IDLE → RUN on `ap_start` = 1; all counters are cleared on this transition.
  - RUN → DONE on the handshake of the last address (`addr_valid & addr_ready & addr_last`).
  - DONE → IDLE unconditionally after one cycle.
- Counters: `col` 0..COLS-1, `row` 0..ROWS-1, `ch` 0..NUM_CH-1, nested with `col` innermost. `off` is a running `row*COLS + col`.
  - `off` increments by 1 per advance and resets to 0 when `ch` advances.
  - No multiplier is used for the in-channel offset.
- Address formation: `ch * CH_SIZE` from the multiplier instance (`CH_SIZE = ROWS*COLS`), added to `off`. The sum is ADDR_W bits wide, zero-extended, with no truncation.
- Load rule: in RUN, the output register loads when `!addr_valid || addr_ready` and the sweep is not exhausted. Each load advances the counters.
- Hold rule: while `addr_valid & !addr_ready`, `addr`, `addr_ch` and `addr_last` are held stable.
- `addr_last` = 1 exactly when the loaded address is `NUM_CH*CH_SIZE - 1`. After that load, no further loads occur.
- `ap_start` in RUN or DONE is ignored. If `ap_start` is held high, a new run begins on the IDLE cycle that follows DONE.
- Elaboration check: `NUM_CH*ROWS*COLS ≤ 2**ADDR_W`, `NUM_CH ≤ 2**CH_W` and `CH_SIZE ≤ 2**OFF_W`. A violation is a fatal error.

## Timing
- Reset values: `addr` = 0, `addr_valid` = 0, `addr_last` = 0, `addr_ch` = 0, `ap_done` = 0, `ap_ready` = 0, `ap_idle` = 1. FSM state is IDLE.
- Reset mid-run: all outputs return to their reset values asynchronously, including `addr_valid` dropping immediately. The in-flight sweep is discarded.
- Latency:
  - `ap_start` sampled at edge N: RUN from N.
  - First `addr_valid` after edge N+1, carrying `addr` = 0.
  - With no backpressure, one address per cycle.
- Sweep with `addr_ready` tied high: 1176 valid cycles; `ap_done` follows the last handshake by one cycle (the DONE state).
- Boundaries:
  - `col` wrap: `row`+1.
  - `row` wrap: `ch`+1 and `off` = 0.
  - Final `ch` wrap: exhausted, no wrap to 0.

## Structure
- Shared package `lenet_predict_pkg`:
  - constants `NUM_CH`, `ROWS`, `COLS`, `CH_SIZE`;
  - width constants `CH_W`, `OFF_W`, `ADDR_W`;
  - FSM state enum `{IDLE, RUN, DONE}`.
- One sub-module: an instance of `lenet_predict_mul_3ns_11ns_13_1_1` with `din0_WIDTH`=3, `din1_WIDTH`=11, `dout_WIDTH`=13.
  - `din0` = `ch`, `din1` = `CH_SIZE`.
  - Combinational, zero latency.
- The adder, counters, FSM and output register are in the top module.

## Test plan
- Full sweep, `addr_ready`=1: exactly 1176 handshakes; addresses 0..1175 in order; `addr_last` only on 1175; `ap_done` and `ap_ready` one pulse each, one cycle after.
- Channel boundary: the handshake after `addr`=195 (`addr_ch`=0) is `addr`=196 (`addr_ch`=1); the handshake after 1175-196=979 is 980 (`addr_ch`=5).
- Backpressure: drop `addr_ready` for 5 cycles while `addr`=13. `addr`=13 is held and valid for all 5 cycles; the next handshake after release is 14; no address is skipped or repeated.
- `ap_start` pulsed mid-run at `addr`=500: the sweep is unaffected; total handshakes remain 1176; `ap_idle` stays 0.
- `ap_rst_n` asserted at `addr`=300: `addr_valid`=0 and `ap_idle`=1 before the next edge. A subsequent `ap_start` restarts at `addr`=0.
- `ap_start` held high across two runs: the second run's first address is 0; DONE and IDLE each last one cycle between runs.

Source files
------------

// File: rtl/lenet_predict_fmap_addr_gen_pkg.sv
// Shared constants and FSM encoding for the LeNet predict feature-map address path.
package lenet_predict_pkg;

    localparam int NUM_CH  = 6;
    localparam int ROWS    = 14;
    localparam int COLS    = 14;
    localparam int CH_SIZE = ROWS * COLS;

    localparam int CH_W    = 3;
    localparam int OFF_W   = 11;
    localparam int ADDR_W  = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/lenet_predict_fmap_addr_gen_if.sv
// Address stream from the feature-map address generator to the buffer read port.
interface lenet_predict_fmap_addr_gen_if #(
    parameter int CH_W   = 3,
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] addr;
    logic              addr_valid;
    logic              addr_ready;
    logic              addr_last;
    logic [CH_W-1:0]   addr_ch;

    modport master (
        output addr, addr_valid, addr_last, addr_ch,
        input  addr_ready
    );

    modport slave (
        input  addr, addr_valid, addr_last, addr_ch,
        output addr_ready
    );
endinterface

// File: rtl/lenet_predict_fmap_addr_gen_mul.sv
// Unsigned combinational multiplier, zero latency; forms the per-channel base address.
module lenet_predict_mul_3ns_11ns_13_1_1 #(
    parameter int din0_WIDTH = 3,
    parameter int din1_WIDTH = 11,
    parameter int dout_WIDTH = 13
) (
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic [dout_WIDTH-1:0] dout
);
    logic [dout_WIDTH-1:0] a;
    logic [dout_WIDTH-1:0] b;

    assign a    = dout_WIDTH'(din0);
    assign b    = dout_WIDTH'(din1);
    assign dout = a * b;
endmodule

// File: rtl/lenet_predict_fmap_addr_gen.sv
// Sweeps ch/row/col over one feature map and streams flat buffer addresses
// (ch*CH_SIZE + row*COLS + col) under valid/ready, framed by ap_start/ap_done.
module lenet_predict_fmap_addr_gen
    import lenet_predict_pkg::*;
#(
    parameter int NUM_CH = lenet_predict_pkg::NUM_CH,
    parameter int ROWS   = lenet_predict_pkg::ROWS,
    parameter int COLS   = lenet_predict_pkg::COLS,
    parameter int CH_W   = lenet_predict_pkg::CH_W,
    parameter int OFF_W  = lenet_predict_pkg::OFF_W,
    parameter int ADDR_W = lenet_predict_pkg::ADDR_W
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic ap_start,
    output logic ap_done,
    output logic ap_idle,
    output logic ap_ready,
    lenet_predict_fmap_addr_gen_if.master fmap
);
    localparam int CH_SIZE = ROWS * COLS;
    localparam int COL_W   = $clog2(COLS + 1);
    localparam int ROW_W   = $clog2(ROWS + 1);

    if (NUM_CH * ROWS * COLS > 2 ** ADDR_W) begin : g_bad_addr_w
        $fatal(1, "NUM_CH*ROWS*COLS does not fit in ADDR_W");
    end
    if (NUM_CH > 2 ** CH_W) begin : g_bad_ch_w
        $fatal(1, "NUM_CH does not fit in CH_W");
    end
    if (CH_SIZE > 2 ** OFF_W) begin : g_bad_off_w
        $fatal(1, "CH_SIZE does not fit in OFF_W");
    end

    state_t state, state_nxt;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [CH_W-1:0]   ch;
    logic [OFF_W-1:0]  off;
    logic              exhausted;

    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              last_q;
    logic [CH_W-1:0]   ch_q;

    logic [ADDR_W-1:0] ch_base;
    logic [ADDR_W-1:0] sum;
    logic              col_end, row_end, ch_end, is_final;
    logic              load, last_hs;

    lenet_predict_mul_3ns_11ns_13_1_1 #(
        .din0_WIDTH (CH_W),
        .din1_WIDTH (OFF_W),
        .dout_WIDTH (ADDR_W)
    ) u_mul (
        .din0 (ch),
        .din1 (OFF_W'(CH_SIZE)),
        .dout (ch_base)
    );

    assign sum      = ch_base + ADDR_W'(off);
    assign col_end  = (col == COL_W'(COLS - 1));
    assign row_end  = (row == ROW_W'(ROWS - 1));
    assign ch_end   = (ch == CH_W'(NUM_CH - 1));
    assign is_final = col_end && row_end && ch_end;

    assign load    = (state == RUN) && (!valid_q || fmap.addr_ready) && !exhausted;
    assign last_hs = valid_q && fmap.addr_ready && last_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_start) state_nxt = RUN;
            RUN:     if (last_hs)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ap_idle  = (state == IDLE);
        ap_done  = (state == DONE);
        ap_ready = (state == DONE);
    end

    // Counters advance only when the output register accepts a new address.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            off       <= '0;
            exhausted <= 1'b0;
            addr_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ch_q      <= '0;
        end else if (state == IDLE && ap_start) begin
            col       <= '0;
            row       <= '0;
            ch        <= '0;
            off       <= '0;
            exhausted <= 1'b0;
        end else if (load) begin
            addr_q  <= sum;
            ch_q    <= ch;
            last_q  <= is_final;
            valid_q <= 1'b1;
            if (!col_end) begin
                col <= col + COL_W'(1);
                off <= off + OFF_W'(1);
            end else if (!row_end) begin
                col <= '0;
                row <= row + ROW_W'(1);
                off <= off + OFF_W'(1);
            end else if (!ch_end) begin
                col <= '0;
                row <= '0;
                off <= '0;
                ch  <= ch + CH_W'(1);
            end else begin
                exhausted <= 1'b1;
            end
        end else if (fmap.addr_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign fmap.addr       = addr_q;
    assign fmap.addr_valid = valid_q;
    assign fmap.addr_last  = last_q;
    assign fmap.addr_ch    = ch_q;

endmodule

// File: tb/tb_lenet_predict_fmap_addr_gen.sv
// Directed bench for the feature-map address generator.
module tb_lenet_predict_fmap_addr_gen;

    logic ap_clk;
    logic ap_rst_n;
    logic ap_start;
    logic ap_done;
    logic ap_idle;
    logic ap_ready;

    int checks   = 0;
    int failures = 0;

    lenet_predict_fmap_addr_gen_if #(.CH_W(3), .ADDR_W(13)) fm ();

    lenet_predict_fmap_addr_gen dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .ap_start (ap_start),
        .ap_done  (ap_done),
        .ap_idle  (ap_idle),
        .ap_ready (ap_ready),
        .fmap     (fm.master)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Runs from the negedge after the start edge until ap_done is seen.
    task automatic sweep(input bit bp_en, input bit pulse_en, input bit keep_start);
        int hs = 0, exp_addr = 0, cyc = 0, last_hs_cyc = -100;
        int order_err = 0, last_err = 0, ch_err = 0, idle_err = 0, bp = 0, bp_err = 0;
        bit pulsed = 0, done = 0;
        logic [12:0] prev_addr = '0;
        logic [2:0]  prev_ch = '0;
        while (!done && cyc < 3000) begin
            @(negedge ap_clk);
            cyc++;
            if (ap_done) begin
                done = 1;
                check("done_one_after_last", cyc - last_hs_cyc, 1);
                check("ready_with_done", ap_ready, 1);
                check("valid_low_in_done", fm.addr_valid, 0);
            end else begin
                if (ap_idle) idle_err++;
                ap_start = keep_start;
                fm.addr_ready = 1'b1;
                if (bp_en && bp < 5 && (bp > 0 || (fm.addr_valid && fm.addr == 13))) begin
                    fm.addr_ready = 1'b0;
                    bp++;
                    if (!(fm.addr_valid && fm.addr == 13 && !fm.addr_last)) bp_err++;
                end
                if (pulse_en && !pulsed && fm.addr_valid && fm.addr == 500) begin
                    ap_start = 1'b1;
                    pulsed = 1;
                end
                if (fm.addr_valid && fm.addr_ready) begin
                    if (hs == 0) check("first_addr_zero", fm.addr, 0);
                    if (fm.addr != 13'(exp_addr)) order_err++;
                    if (fm.addr_ch != 3'(exp_addr / 196)) ch_err++;
                    if (fm.addr_last != (exp_addr == 1175)) last_err++;
                    if (fm.addr == 196) begin
                        check("ch0_prev_addr", prev_addr, 195);
                        check("ch0_prev_ch", prev_ch, 0);
                        check("ch1_first_ch", fm.addr_ch, 1);
                    end
                    if (fm.addr == 980) begin
                        check("ch5_prev_addr", prev_addr, 979);
                        check("ch5_first_ch", fm.addr_ch, 5);
                    end
                    prev_addr = fm.addr;
                    prev_ch   = fm.addr_ch;
                    exp_addr++;
                    hs++;
                    last_hs_cyc = cyc;
                end
            end
        end
        check("sweep_done_seen", done, 1);
        check("handshake_count", hs, 1176);
        check("addr_order_errors", order_err, 0);
        check("addr_ch_errors", ch_err, 0);
        check("addr_last_errors", last_err, 0);
        check("idle_low_in_run", idle_err, 0);
        if (bp_en) begin
            check("bp_cycles", bp, 5);
            check("bp_hold_errors", bp_err, 0);
        end
        if (pulse_en) check("start_pulse_applied", pulsed, 1);
    endtask

    initial begin
        ap_rst_n      = 1'b0;
        ap_start      = 1'b0;
        fm.addr_ready = 1'b0;
        #12;
        check("rst_addr", fm.addr, 0);
        check("rst_valid", fm.addr_valid, 0);
        check("rst_last", fm.addr_last, 0);
        check("rst_ch", fm.addr_ch, 0);
        check("rst_done", ap_done, 0);
        check("rst_ready", ap_ready, 0);
        check("rst_idle", ap_idle, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Run 1: full sweep with backpressure at 13 and a stray start at 500.
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        check("run_idle_low", ap_idle, 0);
        check("first_cycle_no_valid", fm.addr_valid, 0);
        sweep(1'b1, 1'b1, 1'b0);
        @(negedge ap_clk);
        check("done_single_pulse", ap_done, 0);
        check("back_to_idle", ap_idle, 1);

        // Run 2: reset while addr 300 is presented.
        ap_start = 1'b1;
        fm.addr_ready = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        begin
            int n = 0;
            while (!(fm.addr_valid && fm.addr == 300) && n < 1000) begin
                @(negedge ap_clk);
                n++;
            end
            check("reached_addr_300", n < 1000, 1);
        end
        ap_rst_n = 1'b0;
        #1;
        check("midrst_valid", fm.addr_valid, 0);
        check("midrst_idle", ap_idle, 1);
        check("midrst_addr", fm.addr, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;

        // Run 3 and 4: start held high across two back-to-back runs.
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        sweep(1'b0, 1'b0, 1'b1);
        @(negedge ap_clk);
        check("held_idle_one_cycle", ap_idle, 1);
        check("held_done_cleared", ap_done, 0);
        sweep(1'b0, 1'b0, 1'b0);
        @(negedge ap_clk);
        check("final_idle", ap_idle, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
